// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: state encoding and default widths shared by the memory bus arbiter
package mem_bus_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT} state_t;
  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_DATA_WIDTH = 32;
endpackage

// File: rtl/mem_bus_arbiter_rr.sv
// rr_arbiter: one-hot round-robin pick starting at ptr and wrapping past N-1
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);
  logic [IW-1:0] j;
  always_comb begin
    idx = '0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) idx = j;
    end
    gnt = |req ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter serialising masters onto one memory port
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int MEM_LATENCY = 1
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_MASTERS-1:0]             m_req,
  input  logic [NUM_MASTERS-1:0]             m_we,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0]  m_addr,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0]  m_wdata,
  input  logic [NUM_MASTERS*DATA_WIDTH/8-1:0] m_be,
  output logic [NUM_MASTERS-1:0]             m_gnt,
  output logic [NUM_MASTERS-1:0]             m_rvalid,
  output logic [DATA_WIDTH-1:0]              m_rdata,
  output logic [ADDR_WIDTH-1:0]              mem_addr,
  output logic [DATA_WIDTH-1:0]              mem_wdata,
  output logic [DATA_WIDTH/8-1:0]            mem_be,
  output logic                               mem_r_enable,
  output logic                               mem_w_enable,
  input  logic [DATA_WIDTH-1:0]              mem_rdata
);
  localparam int IW = $clog2(NUM_MASTERS);
  localparam int BW = DATA_WIDTH / 8;
  localparam int CW = MEM_LATENCY > 1 ? $clog2(MEM_LATENCY) : 1;
  state_t state, state_nxt;
  logic [NUM_MASTERS-1:0] arb_gnt;
  logic [IW-1:0] winner, owner, ptr;
  logic [CW-1:0] cnt;
  logic we_q, done;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [BW-1:0] be_q;
  rr_arbiter #(.N(NUM_MASTERS)) u_rr (
    .req(m_req),
    .ptr(ptr),
    .gnt(arb_gnt),
    .idx(winner)
  );
  assign done = state == WAIT && cnt == '0;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = state == IDLE ? (|m_req ? ACCESS : IDLE) : state == ACCESS ? WAIT : (done ? IDLE : WAIT);
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      owner   <= '0;
      ptr     <= '0;
      cnt     <= '0;
    end else begin
      if (state == IDLE && |m_req) begin
        we_q    <= m_we[winner];
        addr_q  <= m_addr[winner*ADDR_WIDTH +: ADDR_WIDTH];
        wdata_q <= m_wdata[winner*DATA_WIDTH +: DATA_WIDTH];
        be_q    <= m_be[winner*BW +: BW];
        owner   <= winner;
        ptr     <= IW'((int'(winner) + 1) % NUM_MASTERS);
      end
      if (state == ACCESS) cnt <= CW'(MEM_LATENCY - 1);
      else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
    end
  end
  always_comb begin
    m_gnt        = state == IDLE && reset_n ? arb_gnt : '0;
    m_rvalid     = done ? NUM_MASTERS'(1) << owner : '0;
    m_rdata      = done && !we_q ? mem_rdata : '0;
    mem_r_enable = state == ACCESS && !we_q;
    mem_w_enable = state == ACCESS && we_q;
  end
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed checks on a 2-master/latency-1 and a 4-master/latency-3 arbiter
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;
  int vectors = 0;
  int miscompares = 0;
  logic [1:0] a_req, a_we, a_gnt, a_rvalid;
  logic [63:0] a_addr, a_wdata;
  logic [7:0] a_be;
  logic [31:0] a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic [3:0] a_mem_be;
  logic a_mem_re, a_mem_we;
  logic [3:0] b_req, b_we, b_gnt, b_rvalid;
  logic [127:0] b_addr, b_wdata;
  logic [15:0] b_be;
  logic [31:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
  logic [3:0] b_mem_be;
  logic b_mem_re, b_mem_we;
  mem_bus_arbiter dut_a (
    .clk(clk), .reset_n(reset_n),
    .m_req(a_req), .m_we(a_we), .m_addr(a_addr), .m_wdata(a_wdata), .m_be(a_be),
    .m_gnt(a_gnt), .m_rvalid(a_rvalid), .m_rdata(a_rdata),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_be(a_mem_be),
    .mem_r_enable(a_mem_re), .mem_w_enable(a_mem_we), .mem_rdata(a_mem_rdata)
  );
  mem_bus_arbiter #(.NUM_MASTERS(4), .MEM_LATENCY(3)) dut_b (
    .clk(clk), .reset_n(reset_n),
    .m_req(b_req), .m_we(b_we), .m_addr(b_addr), .m_wdata(b_wdata), .m_be(b_be),
    .m_gnt(b_gnt), .m_rvalid(b_rvalid), .m_rdata(b_rdata),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_be(b_mem_be),
    .mem_r_enable(b_mem_re), .mem_w_enable(b_mem_we), .mem_rdata(b_mem_rdata)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  initial begin
    logic [1:0] eg, ev;
    a_req = '0; a_we = '0; a_addr = '0; a_wdata = '0; a_be = '0; a_mem_rdata = '0;
    b_req = '0; b_we = '0; b_addr = '0; b_wdata = '0; b_be = '0; b_mem_rdata = '0;
    a_req = 2'b11;
    b_req = 4'b1111;
    step(); #1;
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_a_rvalid", a_rvalid, 0);
    chk("rst_a_mem_re", a_mem_re, 0);
    chk("rst_a_mem_addr", a_mem_addr, 0);
    chk("rst_b_gnt", b_gnt, 0);
    a_req = '0;
    b_req = '0;
    step(); reset_n = 1'b1;
    step(); a_req = 2'b01; a_addr[31:0] = 32'h100; #1;
    chk("rd_gnt", a_gnt, 2'b01);
    step(); a_req = '0; a_mem_rdata = 32'hDEADBEEF; #1;
    chk("rd_mem_re", a_mem_re, 1);
    chk("rd_mem_we", a_mem_we, 0);
    chk("rd_mem_addr", a_mem_addr, 32'h100);
    chk("rd_gnt_busy", a_gnt, 0);
    step(); #1;
    chk("rd_rvalid", a_rvalid, 2'b01);
    chk("rd_rdata", a_rdata, 32'hDEADBEEF);
    step(); #1;
    chk("rd_idle_rvalid", a_rvalid, 0);
    chk("rd_idle_re", a_mem_re, 0);
    chk("rd_hold_addr", a_mem_addr, 32'h100);
    step();
    a_req = 2'b10; a_we = 2'b10; a_addr[63:32] = 32'h20; a_wdata[63:32] = 32'h55AA00FF; a_be[7:4] = 4'b0011; #1;
    chk("wr_gnt", a_gnt, 2'b10);
    step(); a_req = '0; #1;
    chk("wr_mem_we", a_mem_we, 1);
    chk("wr_mem_re", a_mem_re, 0);
    chk("wr_mem_addr", a_mem_addr, 32'h20);
    chk("wr_mem_be", a_mem_be, 4'b0011);
    chk("wr_mem_wdata", a_mem_wdata, 32'h55AA00FF);
    step(); #1;
    chk("wr_rvalid", a_rvalid, 2'b10);
    chk("wr_rdata", a_rdata, 0);
    step(); reset_n = 1'b0; a_we = '0;
    step(); reset_n = 1'b1; a_req = 2'b11;
    for (int s = 0; s < 12; s++) begin
      if (s > 0) step();
      #1;
      eg = (s % 3 == 0) ? (((s / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      ev = (s % 3 == 2) ? (((s / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      chk($sformatf("cont_gnt_%0d", s), a_gnt, eg);
      chk($sformatf("cont_rvalid_%0d", s), a_rvalid, ev);
    end
    a_req = '0;
    step(); a_req = 2'b01; #1;
    chk("ab_gnt", a_gnt, 2'b01);
    step(); a_req = '0; #1;
    chk("ab_mem_re_on", a_mem_re, 1);
    step(); reset_n = 1'b0; #1;
    chk("ab_rvalid", a_rvalid, 0);
    chk("ab_rdata", a_rdata, 0);
    chk("ab_mem_addr", a_mem_addr, 0);
    chk("ab_mem_re", a_mem_re, 0);
    step(); #1;
    chk("ab_rvalid_hold", a_rvalid, 0);
    reset_n = 1'b1; a_req = 2'b11; #1;
    chk("ab_first_gnt", a_gnt, 2'b01);
    step(); a_req = '0;
    step();
    step(); b_req = 4'b0100; b_addr[95:64] = 32'h300; b_mem_rdata = 32'h12345678; #1;
    chk("lat_gnt_m2", b_gnt, 4'b0100);
    step(); b_req = 4'b1001; #1;
    chk("lat_mem_re", b_mem_re, 1);
    chk("lat_mem_addr", b_mem_addr, 32'h300);
    chk("lat_gnt_busy1", b_gnt, 0);
    for (int s = 2; s <= 4; s++) begin
      step(); #1;
      chk($sformatf("lat_gnt_busy%0d", s), b_gnt, 0);
      chk($sformatf("lat_rvalid_%0d", s), b_rvalid, s == 4 ? 4'b0100 : 4'b0000);
    end
    chk("lat_rdata", b_rdata, 32'h12345678);
    step(); #1;
    chk("wrap_gnt_m3", b_gnt, 4'b1000);
    step(); b_req = 4'b0001; #1;
    chk("wrap_busy1", b_gnt, 0);
    for (int s = 2; s <= 4; s++) begin
      step(); #1;
      chk($sformatf("wrap_busy%0d", s), b_gnt, 0);
      chk($sformatf("wrap_rvalid_%0d", s), b_rvalid, s == 4 ? 4'b1000 : 4'b0000);
    end
    step(); #1;
    chk("wrap_gnt_m0", b_gnt, 4'b0001);
    b_req = '0;
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
